pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Central stall/flush controller for the five-stage MIPS pipeline. It drives the write-enable and flush inputs of the PC and the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It resolves four conditions in a fixed priority order: data-memory wait, multi-cycle divide occupancy, taken branch, and load-use hazard. It also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- DIV_CYCLES, 32, cycles the divider occupies EX; legal range ≥ 2.
- MEM_TIMEOUT, 1024, maximum consecutive memory-wait cycles before the timeout flag sets; legal range ≥ 1.
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-high.
- id_rs, id_rt, in, 5 each, source registers of the instruction in ID.
- id_uses_rs, id_uses_rt, in, 1 each, ID actually reads rs / rt.
- ex_mem_read, in, 1, instruction in EX is a load.
- ex_rd, in, 5, destination register of the instruction in EX.
- ex_branch_taken, in, 1, branch resolved taken in EX.
- ex_div_start, in, 1, divide instruction present in EX; level-sensitive, held while EX is frozen.
- mem_req, in, 1, MEM stage accessing data memory.
- mem_ready, in, 1, data memory completes the access this cycle.
- pc_wr, ifid_wr, idex_wr, exmem_wr, memwb_wr, out, 1 each, register load enables; 0 holds the register.
- ifid_flush, idex_flush, exmem_flush, memwb_flush, out, 1 each, when asserted with the matching _wr, the register loads zero (bubble).
- div_done, out, 1, one-cycle pulse on the divider release cycle.
- mem_timeout, out, 1, sticky error flag.
- stall_count, out, 32, count of cycles with pc_wr = 0; saturates at 0xFFFFFFFF.

## Operation
- States: RUN and DIV_WAIT. Also holds div_cnt (ceil(log2 DIV_CYCLES) bits), mem_wait_cnt (saturating), mem_timeout and stall_count.
- Signal names used below:
  - memstall = mem_req & ~mem_ready.
  - divstall = (RUN & ex_div_start) | (DIV_WAIT & div_cnt ≠ 0).
  - loaduse = ex_mem_read & ex_rd ≠ 0 & ((id_uses_rs & id_rs = ex_rd) | (id_uses_rt & id_rt = ex_rd)).
- Defaults: all _wr = 1 and all _flush = 0.
- Priority 1, memstall:
  - pc, ifid, idex and exmem _wr = 0.
  - memwb_wr = 1 and memwb_flush = 1.
  - All lower-priority actions are suppressed.
- Priority 2, divstall (no memstall):
  - pc, ifid and idex _wr = 0.
  - exmem_wr = 1 and exmem_flush = 1.
  - memwb runs normally.
- Priority 3, ex_branch_taken (no memstall, no divstall):
  - ifid_flush = 1 and idex_flush = 1.
  - All _wr = 1.
- Priority 4, loaduse (none of the above, no branch):
  - pc_wr = 0 and ifid_wr = 0.
  - idex_flush = 1.
  - exmem and memwb run normally.
- RUN → DIV_WAIT when ex_div_start & ~memstall; div_cnt loads DIV_CYCLES−1.
- In DIV_WAIT, div_cnt decrements each cycle while non-zero, whether or not memstall is asserted.
- DIV_WAIT with div_cnt = 0:
  - With ~memstall: this is the release cycle. div_done = 1, there is no freeze, and next state is RUN.
  - With memstall: remain in DIV_WAIT and hold div_cnt at 0; div_done stays 0.
- mem_wait_cnt:
  - Increments each memstall cycle, clears on any cycle without memstall.
  - mem_timeout sets when mem_wait_cnt reaches MEM_TIMEOUT and stays set until reset.
- stall_count increments on every cycle with pc_wr = 0, saturating.

## Timing
- Outputs are combinational from current state and inputs, so a stall takes effect in the same cycle as its cause.
- All state is registered on the rising edge of clk.
- While rst = 1:
  - all _wr = 0 and all _flush = 1;
  - div_done = 0, mem_timeout = 0, stall_count = 0;
  - state = RUN, div_cnt = 0, mem_wait_cnt = 0.
- Reset asserted mid-divide or mid-wait aborts immediately; the first cycle after deassertion is RUN with no stall.
- Divide with no memory wait: ex_div_start first seen in cycle C0.
  - pc/ifid/idex are frozen in cycles C0 … C0+DIV_CYCLES−1, which is DIV_CYCLES cycles.
  - div_done and the release occur in cycle C0+DIV_CYCLES.
- Load-use costs exactly 1 bubble cycle. A taken branch costs 2 flushed slots.
- A branch coincident with a memstall or divstall is deferred: EX is frozen, so ex_branch_taken persists and the flush fires on the first cycle without a stall.
- memstall stalling pc ⇒ stall_count increments in that cycle.

## Test plan
- Reset, then release with all inputs 0 → all _wr = 1, all _flush = 0, stall_count = 0.
- Load-use: ex_mem_read = 1, ex_rd = 8, id_rs = 8, id_uses_rs = 1 for 1 cycle → pc_wr = ifid_wr = 0 and idex_flush = 1 for 1 cycle; stall_count = 1. Repeat with ex_rd = 0 → no stall.
- Divide: DIV_CYCLES = 4, ex_div_start held → 4 frozen cycles with exmem_flush = 1, then div_done pulse in the 5th cycle; stall_count = 4.
- Branch together with load-use → branch wins: ifid_flush = idex_flush = 1 and pc_wr = 1. Branch together with memstall → no flush until mem_ready, then flush in the release cycle.
- Memory wait of 3 cycles during DIV_WAIT with div_cnt = 1 → memwb bubbles for 3 cycles; release and div_done occur only after mem_ready.
- MEM_TIMEOUT = 4, memstall held 6 cycles → mem_timeout rises after the 4th wait cycle and stays set after mem_ready; rst clears it.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: memory wait, divide occupancy,
// taken branch and load-use, in that priority, plus stall and memory-timeout bookkeeping.
module pipe_hazard_ctrl #(
    parameter int DIV_CYCLES  = 32,
    parameter int MEM_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_branch_taken,
    input  logic        ex_div_start,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        pc_wr,
    output logic        ifid_wr,
    output logic        idex_wr,
    output logic        exmem_wr,
    output logic        memwb_wr,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        memwb_flush,
    output logic        div_done,
    output logic        mem_timeout,
    output logic [31:0] stall_count
);

    localparam int DCW = $clog2(DIV_CYCLES);
    localparam int MWW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [DCW-1:0] DIV_LOAD  = DCW'(DIV_CYCLES - 1);
    localparam logic [DCW-1:0] DIV_ONE   = DCW'(1);
    localparam logic [MWW-1:0] MEM_LIMIT = MWW'(MEM_TIMEOUT);
    localparam logic [MWW-1:0] MW_ONE    = MWW'(1);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } state_t;

    state_t         state_r, state_nxt_s;
    logic [DCW-1:0] div_cnt_r, div_cnt_nxt_s;
    logic [MWW-1:0] mem_wait_cnt_r, mem_wait_nxt_s;
    logic           mem_timeout_r, mem_timeout_nxt_s;
    logic [31:0]    stall_count_r, stall_count_nxt_s;
    logic           memstall_s, divstall_s, loaduse_s, release_s;

    // Hazard conditions derived from the current state and pipeline inputs
    always_comb begin
        memstall_s = mem_req & ~mem_ready;
        divstall_s = ((state_r == RUN) & ex_div_start) |
                     ((state_r == DIV_WAIT) & (div_cnt_r != {DCW{1'b0}}));
        loaduse_s  = ex_mem_read & (ex_rd != 5'd0) &
                     ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));
        release_s  = (state_r == DIV_WAIT) & (div_cnt_r == {DCW{1'b0}}) & ~memstall_s;
    end

    // Priority-resolved register enables and bubble requests
    always_comb begin
        pc_wr       = 1'b1;
        ifid_wr     = 1'b1;
        idex_wr     = 1'b1;
        exmem_wr    = 1'b1;
        memwb_wr    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        div_done    = release_s & ~rst;
        if (rst) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_wr     = 1'b0;
            exmem_wr    = 1'b0;
            memwb_wr    = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
            memwb_flush = 1'b1;
        end else if (memstall_s) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_wr     = 1'b0;
            exmem_wr    = 1'b0;
            memwb_flush = 1'b1;
        end else if (divstall_s) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_wr     = 1'b0;
            exmem_flush = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
        end else if (loaduse_s) begin
            pc_wr       = 1'b0;
            ifid_wr     = 1'b0;
            idex_flush  = 1'b1;
        end else begin
            pc_wr       = 1'b1;
        end
    end

    // Divider occupancy FSM; the counter keeps running under a memory wait
    always_comb begin
        state_nxt_s   = state_r;
        div_cnt_nxt_s = div_cnt_r;
        case (state_r)
            RUN: begin
                if (ex_div_start & ~memstall_s) begin
                    state_nxt_s   = DIV_WAIT;
                    div_cnt_nxt_s = DIV_LOAD;
                end else begin
                    state_nxt_s   = RUN;
                end
            end
            DIV_WAIT: begin
                if (div_cnt_r != {DCW{1'b0}}) begin
                    div_cnt_nxt_s = div_cnt_r - DIV_ONE;
                end else if (~memstall_s) begin
                    state_nxt_s   = RUN;
                end else begin
                    state_nxt_s   = DIV_WAIT;
                end
            end
            default: begin
                state_nxt_s   = RUN;
                div_cnt_nxt_s = {DCW{1'b0}};
            end
        endcase
    end

    // Saturating wait-run and stall counters, sticky timeout
    always_comb begin
        if (!memstall_s) begin
            mem_wait_nxt_s = {MWW{1'b0}};
        end else if (mem_wait_cnt_r == MEM_LIMIT) begin
            mem_wait_nxt_s = mem_wait_cnt_r;
        end else begin
            mem_wait_nxt_s = mem_wait_cnt_r + MW_ONE;
        end
        mem_timeout_nxt_s = mem_timeout_r | (mem_wait_nxt_s == MEM_LIMIT);
        if (!pc_wr && (stall_count_r != 32'hFFFF_FFFF)) begin
            stall_count_nxt_s = stall_count_r + 32'd1;
        end else begin
            stall_count_nxt_s = stall_count_r;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= RUN;
            div_cnt_r      <= {DCW{1'b0}};
            mem_wait_cnt_r <= {MWW{1'b0}};
            mem_timeout_r  <= 1'b0;
            stall_count_r  <= 32'd0;
        end else begin
            state_r        <= state_nxt_s;
            div_cnt_r      <= div_cnt_nxt_s;
            mem_wait_cnt_r <= mem_wait_nxt_s;
            mem_timeout_r  <= mem_timeout_nxt_s;
            stall_count_r  <= stall_count_nxt_s;
        end
    end

    assign mem_timeout = mem_timeout_r;
    assign stall_count = stall_count_r;

endmodule
